// File: rtl/led_driver_pkg.sv
// Shared types and helpers for the LED PWM driver: MODE register layout,
// per-LED output select encoding and the register address map.
package led_driver_pkg;

    localparam logic [7:0] MODE_RESET = 8'h10;

    typedef struct packed {
        logic       auto_increment;
        logic       reserved6;
        logic       dim_blink;
        logic       sleep;
        logic       output_change;
        logic       invert;
        logic [1:0] reserved;
    } reg_mode_t;

    typedef enum logic [1:0] {
        LED_OFF        = 2'd0,
        LED_ON         = 2'd1,
        LED_INDIVIDUAL = 2'd2,
        LED_GROUP      = 2'd3
    } led_out_enum_t;

    typedef enum logic [2:0] {
        REG_MODE,
        REG_PWM,
        REG_GRPPWM,
        REG_GRPFREQ,
        REG_LEDOUT
    } reg_kind_t;

    // Address of a register of the given kind; idx selects the LED for PWM
    // registers and the byte for LEDOUT registers.
    function automatic int reg_addr_f(reg_kind_t kind, int idx, int num_leds);
        case (kind)
            REG_MODE:    return 0;
            REG_PWM:     return 1 + idx;
            REG_GRPPWM:  return num_leds + 1;
            REG_GRPFREQ: return num_leds + 2;
            REG_LEDOUT:  return num_leds + 3 + idx;
            default:     return 0;
        endcase
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: fast counter pcnt, group counter gcnt and blink divider fdiv.
// All counters are held at zero while asleep so that wake-up starts a fresh period.
module led_pwm_timebase
    import led_driver_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sleep_i,
    input  logic                 blink_i,
    input  logic [DATA_BITS-1:0] grpfreq_i,
    input  logic [PWM_BITS-1:0]  grp_duty_i,
    output logic [PWM_BITS-1:0]  pcnt_o,
    output logic                 pwrap_o,
    output logic                 group_on_o
);

    logic [PWM_BITS-1:0]  pcnt_q, pcnt_d;
    logic [PWM_BITS-1:0]  gcnt_q, gcnt_d;
    logic [DATA_BITS-1:0] fdiv_q, fdiv_d;
    logic                 period_end;

    // Next-state for the counters: gcnt steps once per PWM period in dim mode,
    // or once per (GRPFREQ+1) periods in blink mode.
    always_comb begin
        period_end = (pcnt_q == {PWM_BITS{1'b1}});
        pcnt_d     = pcnt_q + PWM_BITS'(1);
        gcnt_d     = gcnt_q;
        fdiv_d     = fdiv_q;
        if (!blink_i || (fdiv_q > grpfreq_i)) begin
            fdiv_d = '0;
        end
        if (period_end) begin
            if (blink_i) begin
                if (fdiv_q >= grpfreq_i) begin
                    fdiv_d = '0;
                    gcnt_d = gcnt_q + PWM_BITS'(1);
                end else begin
                    fdiv_d = fdiv_q + DATA_BITS'(1);
                end
            end else begin
                gcnt_d = gcnt_q + PWM_BITS'(1);
            end
        end
        if (sleep_i) begin
            pcnt_d = '0;
            gcnt_d = '0;
            fdiv_d = '0;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q <= '0;
            gcnt_q <= '0;
            fdiv_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            gcnt_q <= gcnt_d;
            fdiv_q <= fdiv_d;
        end
    end

    assign pcnt_o     = pcnt_q;
    assign pwrap_o    = period_end & ~sleep_i;
    assign group_on_o = (gcnt_q < grp_duty_i);

endmodule

// File: rtl/led_pwm_array.sv
// N-channel LED PWM controller: register file, shadow copies, per-LED output
// mux and the bus read path. Timing comes from led_pwm_timebase.
module led_pwm_array
    import led_driver_pkg::*;
#(
    parameter int NUM_LEDS  = 4,
    parameter int PWM_BITS  = 8,
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sleep,
    input  logic [ADDR_BITS-1:0] bus_addr,
    input  logic                 bus_w_en,
    input  logic                 bus_r_en,
    input  logic [DATA_BITS-1:0] bus_wdata,
    output logic [DATA_BITS-1:0] bus_rdata,
    output logic                 bus_rvalid,
    output logic [NUM_LEDS-1:0]  led_out
);

    localparam int NUM_LEDOUT = (NUM_LEDS + 3) / 4;

    reg_mode_t            mode_q, mode_d;
    logic [DATA_BITS-1:0] pwm_q [NUM_LEDS];
    logic [DATA_BITS-1:0] pwm_d [NUM_LEDS];
    logic [DATA_BITS-1:0] grppwm_q, grppwm_d;
    logic [DATA_BITS-1:0] grpfreq_q, grpfreq_d;
    logic [7:0]           ledout_q [NUM_LEDOUT];
    logic [7:0]           ledout_d [NUM_LEDOUT];

    logic [DATA_BITS-1:0] pwm_sh_q [NUM_LEDS];
    logic [DATA_BITS-1:0] pwm_sh_d [NUM_LEDS];
    logic [DATA_BITS-1:0] grppwm_sh_q, grppwm_sh_d;
    logic [7:0]           ledout_sh_q [NUM_LEDOUT];
    logic [7:0]           ledout_sh_d [NUM_LEDOUT];

    logic [DATA_BITS-1:0] pwm_eff [NUM_LEDS];
    logic [DATA_BITS-1:0] grppwm_eff;
    logic [7:0]           ledout_eff [NUM_LEDOUT];

    logic [PWM_BITS-1:0]  duty [NUM_LEDS];
    logic [NUM_LEDS-1:0]  ind_on, raw_on;
    led_out_enum_t        led_sel [NUM_LEDS];

    logic [DATA_BITS-1:0] rdata_q, rdata_d, rd_mux;
    logic                 rvalid_q, rvalid_d;
    logic [NUM_LEDS-1:0]  led_out_q, led_out_d;

    logic                 sleep_eff;
    logic [PWM_BITS-1:0]  pcnt;
    logic                 pwrap;
    logic                 group_on;

    assign sleep_eff = sleep | mode_q.sleep;

    led_pwm_timebase #(
        .PWM_BITS  (PWM_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_timebase (
        .clk        (clk),
        .reset      (reset),
        .sleep_i    (sleep_eff),
        .blink_i    (mode_q.dim_blink),
        .grpfreq_i  (grpfreq_q),
        .grp_duty_i (grppwm_eff[DATA_BITS-1 -: PWM_BITS]),
        .pcnt_o     (pcnt),
        .pwrap_o    (pwrap),
        .group_on_o (group_on)
    );

    // Register write decode; unmapped addresses fall through untouched.
    always_comb begin
        mode_d    = mode_q;
        pwm_d     = pwm_q;
        grppwm_d  = grppwm_q;
        grpfreq_d = grpfreq_q;
        ledout_d  = ledout_q;
        if (bus_w_en) begin
            if (bus_addr == ADDR_BITS'(reg_addr_f(REG_MODE, 0, NUM_LEDS)))
                mode_d = reg_mode_t'(bus_wdata[7:0]);
            for (int i = 0; i < NUM_LEDS; i++)
                if (bus_addr == ADDR_BITS'(reg_addr_f(REG_PWM, i, NUM_LEDS)))
                    pwm_d[i] = bus_wdata;
            if (bus_addr == ADDR_BITS'(reg_addr_f(REG_GRPPWM, 0, NUM_LEDS)))
                grppwm_d = bus_wdata;
            if (bus_addr == ADDR_BITS'(reg_addr_f(REG_GRPFREQ, 0, NUM_LEDS)))
                grpfreq_d = bus_wdata;
            for (int k = 0; k < NUM_LEDOUT; k++)
                if (bus_addr == ADDR_BITS'(reg_addr_f(REG_LEDOUT, k, NUM_LEDS)))
                    ledout_d[k] = bus_wdata[7:0];
        end
    end

    // Programmed register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= reg_mode_t'(MODE_RESET);
            pwm_q     <= '{default: '0};
            grppwm_q  <= '0;
            grpfreq_q <= '0;
            ledout_q  <= '{default: '0};
        end else begin
            mode_q    <= mode_d;
            pwm_q     <= pwm_d;
            grppwm_q  <= grppwm_d;
            grpfreq_q <= grpfreq_d;
            ledout_q  <= ledout_d;
        end
    end

    // Shadows follow the registers every cycle unless output_change defers
    // the copy to the end of a PWM period; the output mux picks which to use.
    always_comb begin
        pwm_sh_d    = pwm_sh_q;
        grppwm_sh_d = grppwm_sh_q;
        ledout_sh_d = ledout_sh_q;
        if (!mode_q.output_change || pwrap) begin
            pwm_sh_d    = pwm_q;
            grppwm_sh_d = grppwm_q;
            ledout_sh_d = ledout_q;
        end
        for (int i = 0; i < NUM_LEDS; i++)
            pwm_eff[i] = mode_q.output_change ? pwm_sh_q[i] : pwm_q[i];
        for (int k = 0; k < NUM_LEDOUT; k++)
            ledout_eff[k] = mode_q.output_change ? ledout_sh_q[k] : ledout_q[k];
        grppwm_eff = mode_q.output_change ? grppwm_sh_q : grppwm_q;
    end

    // Shadow registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_sh_q    <= '{default: '0};
            grppwm_sh_q <= '0;
            ledout_sh_q <= '{default: '0};
        end else begin
            pwm_sh_q    <= pwm_sh_d;
            grppwm_sh_q <= grppwm_sh_d;
            ledout_sh_q <= ledout_sh_d;
        end
    end

    // Per-LED output select, polarity and sleep override.
    always_comb begin
        led_out_d = '0;
        ind_on    = '0;
        raw_on    = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            duty[i]    = pwm_eff[i][DATA_BITS-1 -: PWM_BITS];
            ind_on[i]  = (duty[i] == {PWM_BITS{1'b1}}) || (pcnt < duty[i]);
            led_sel[i] = led_out_enum_t'(ledout_eff[i / 4][(i % 4) * 2 +: 2]);
            case (led_sel[i])
                LED_OFF:        raw_on[i] = 1'b0;
                LED_ON:         raw_on[i] = 1'b1;
                LED_INDIVIDUAL: raw_on[i] = ind_on[i];
                LED_GROUP:      raw_on[i] = ind_on[i] & group_on;
                default:        raw_on[i] = 1'b0;
            endcase
            led_out_d[i] = raw_on[i] ^ mode_q.invert;
        end
        if (sleep_eff)
            led_out_d = {NUM_LEDS{mode_q.invert}};
    end

    // Read mux returns the programmed values, never the shadows.
    always_comb begin
        rd_mux = '0;
        if (bus_addr == ADDR_BITS'(reg_addr_f(REG_MODE, 0, NUM_LEDS)))
            rd_mux = DATA_BITS'(mode_q);
        for (int i = 0; i < NUM_LEDS; i++)
            if (bus_addr == ADDR_BITS'(reg_addr_f(REG_PWM, i, NUM_LEDS)))
                rd_mux = pwm_q[i];
        if (bus_addr == ADDR_BITS'(reg_addr_f(REG_GRPPWM, 0, NUM_LEDS)))
            rd_mux = grppwm_q;
        if (bus_addr == ADDR_BITS'(reg_addr_f(REG_GRPFREQ, 0, NUM_LEDS)))
            rd_mux = grpfreq_q;
        for (int k = 0; k < NUM_LEDOUT; k++)
            if (bus_addr == ADDR_BITS'(reg_addr_f(REG_LEDOUT, k, NUM_LEDS)))
                rd_mux = DATA_BITS'(ledout_q[k]);
        rdata_d  = bus_r_en ? rd_mux : rdata_q;
        rvalid_d = bus_r_en;
    end

    // Registered read data, valid strobe and LED drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            led_out_q <= '0;
        end else begin
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            led_out_q <= led_out_d;
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign led_out    = led_out_q;

endmodule

// File: tb/tb_led_pwm_array.sv
// Directed bench for led_pwm_array (4 LEDs, 8-bit PWM). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_led_pwm_array;

    logic       clk = 1'b0;
    logic       reset;
    logic       sleep;
    logic [4:0] bus_addr;
    logic       bus_w_en;
    logic       bus_r_en;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_rvalid;
    logic [3:0] led_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [3:0] exp_led;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    led_pwm_array #(
        .NUM_LEDS  (4),
        .PWM_BITS  (8),
        .DATA_BITS (8),
        .ADDR_BITS (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sleep      (sleep),
        .bus_addr   (bus_addr),
        .bus_w_en   (bus_w_en),
        .bus_r_en   (bus_r_en),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .led_out    (led_out)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Single-cycle register write, called on a falling edge.
    task automatic apply_stimulus(input logic [4:0] addr, input logic [7:0] data);
        bus_addr  = addr;
        bus_wdata = data;
        bus_w_en  = 1'b1;
        @(negedge clk);
        bus_w_en  = 1'b0;
    endtask

    // Single-cycle register read; returns data and valid seen one cycle later.
    task automatic read_reg(input logic [4:0] addr, output logic [7:0] data, output logic valid);
        bus_addr = addr;
        bus_r_en = 1'b1;
        @(negedge clk);
        data     = bus_rdata;
        valid    = bus_rvalid;
        bus_r_en = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic       rv;
        int         errs;
        int         highs;
        logic       exp_bit;

        reset     = 1'b0;
        sleep     = 1'b0;
        bus_addr  = '0;
        bus_w_en  = 1'b0;
        bus_r_en  = 1'b0;
        bus_wdata = '0;

        // Steady-state output patterns: {addr, wdata, led_out after settling, readback}
        vecs[0]  = '{5'd0,  8'h00, 4'h0, 8'h00};
        vecs[1]  = '{5'd7,  8'h55, 4'hF, 8'h55};
        vecs[2]  = '{5'd0,  8'h04, 4'h0, 8'h04};
        vecs[3]  = '{5'd7,  8'h50, 4'h3, 8'h50};
        vecs[4]  = '{5'd0,  8'h00, 4'hC, 8'h00};
        vecs[5]  = '{5'd2,  8'hFF, 4'hC, 8'hFF};
        vecs[6]  = '{5'd7,  8'h59, 4'hF, 8'h59};
        vecs[7]  = '{5'd7,  8'hD9, 4'h7, 8'hD9};
        vecs[8]  = '{5'd11, 8'hAA, 4'h7, 8'h00};
        vecs[9]  = '{5'd6,  8'h03, 4'h7, 8'h03};
        vecs[10] = '{5'd0,  8'h10, 4'h0, 8'h10};
        vecs[11] = '{5'd0,  8'h80, 4'h7, 8'h80};

        // Reset state
        repeat (3) @(negedge clk);
        check_output("reset led_out", led_out, 4'h0);
        check_output("reset rvalid", bus_rvalid, 1'b0);
        check_output("reset rdata", bus_rdata, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        read_reg(5'd0, rd, rv);
        check_output("reset MODE read", rd, 8'h10);
        check_output("reset MODE rvalid", rv, 1'b1);
        @(negedge clk);
        check_output("rvalid pulse", bus_rvalid, 1'b0);

        // Table-driven steady-state patterns
        for (int v = 0; v < 12; v++) begin
            apply_stimulus(vecs[v].addr, vecs[v].wdata);
            repeat (2) @(negedge clk);
            check_output($sformatf("vec%0d led_out", v), led_out, vecs[v].exp_led);
            read_reg(vecs[v].addr, rd, rv);
            check_output($sformatf("vec%0d readback", v), rd, vecs[v].exp_rd);
            check_output($sformatf("vec%0d rvalid", v), rv, 1'b1);
        end
        read_reg(5'd2, rd, rv);
        check_output("PWM1 after unmapped write", rd, 8'hFF);
        read_reg(5'd7, rd, rv);
        check_output("LEDOUT0 after unmapped write", rd, 8'hD9);

        // Individual duty 0x40 from a clean wake-up: exact phase, 64 of 256
        apply_stimulus(5'd0, 8'h10);
        apply_stimulus(5'd1, 8'h40);
        apply_stimulus(5'd7, 8'h02);
        apply_stimulus(5'd0, 8'h00);
        errs  = 0;
        highs = 0;
        for (int s = 1; s <= 256; s++) begin
            @(negedge clk);
            exp_bit = ((s - 1) < 64);
            if (led_out !== {3'b000, exp_bit}) errs++;
            if (led_out[0] === 1'b1) highs++;
        end
        check_output("duty40 phase errors", errs, 0);
        check_output("duty40 high count", highs, 64);

        // All-ones duty is always on
        apply_stimulus(5'd1, 8'hFF);
        @(negedge clk);
        highs = 0;
        for (int s = 0; s < 256; s++) begin
            @(negedge clk);
            if (led_out[0] === 1'b1) highs++;
        end
        check_output("dutyFF high count", highs, 256);

        // output_change: duty write at pcnt=100 takes effect only after pwrap
        apply_stimulus(5'd0, 8'h10);
        apply_stimulus(5'd1, 8'h40);
        apply_stimulus(5'd0, 8'h08);
        repeat (100) @(negedge clk);
        apply_stimulus(5'd1, 8'hC0);
        highs = 0;
        for (int s = 1; s <= 256; s++) begin
            @(negedge clk);
            if (s == 1) check_output("oc no immediate change", led_out[0], 1'b0);
            if (led_out[0] === 1'b1) highs++;
        end
        check_output("oc high count", highs, 101);

        // Blink, GRPFREQ=1, GRPPWM=4, GROUP, PWM=FF: high for 4*512 clocks
        apply_stimulus(5'd0, 8'h10);
        apply_stimulus(5'd1, 8'hFF);
        apply_stimulus(5'd7, 8'h03);
        apply_stimulus(5'd5, 8'h04);
        apply_stimulus(5'd6, 8'h01);
        apply_stimulus(5'd0, 8'h20);
        errs  = 0;
        highs = 0;
        for (int s = 1; s <= 2100; s++) begin
            @(negedge clk);
            exp_bit = (s <= 2048);
            if (led_out !== {3'b000, exp_bit}) errs++;
            if (led_out[0] === 1'b1) highs++;
        end
        check_output("blink phase errors", errs, 0);
        check_output("blink high count", highs, 2048);

        // Same settings in dim mode: high for 4*256 clocks
        apply_stimulus(5'd0, 8'h10);
        apply_stimulus(5'd0, 8'h00);
        errs  = 0;
        highs = 0;
        for (int s = 1; s <= 1100; s++) begin
            @(negedge clk);
            exp_bit = (s <= 1024);
            if (led_out !== {3'b000, exp_bit}) errs++;
            if (led_out[0] === 1'b1) highs++;
        end
        check_output("dim phase errors", errs, 0);
        check_output("dim high count", highs, 1024);

        // Sleep input mid-period with invert, then restart from pcnt=0
        apply_stimulus(5'd0, 8'h14);
        apply_stimulus(5'd1, 8'h40);
        apply_stimulus(5'd7, 8'h56);
        apply_stimulus(5'd0, 8'h04);
        repeat (100) @(negedge clk);
        check_output("pre-sleep led_out", led_out, 4'h1);
        sleep = 1'b1;
        @(negedge clk);
        check_output("sleep led_out", led_out, 4'hF);
        repeat (5) @(negedge clk);
        check_output("sleep hold led_out", led_out, 4'hF);
        sleep = 1'b0;
        errs = 0;
        for (int s = 1; s <= 70; s++) begin
            @(negedge clk);
            exp_bit = !((s - 1) < 64);
            if (led_out !== {3'b000, exp_bit}) errs++;
        end
        check_output("sleep restart phase errors", errs, 0);

        // Read and write to the same address in one cycle
        apply_stimulus(5'd3, 8'h33);
        bus_addr  = 5'd3;
        bus_wdata = 8'h77;
        bus_w_en  = 1'b1;
        bus_r_en  = 1'b1;
        @(negedge clk);
        bus_w_en  = 1'b0;
        bus_r_en  = 1'b0;
        check_output("rw same cycle old data", bus_rdata, 8'h33);
        read_reg(5'd3, rd, rv);
        check_output("rw same cycle new data", rd, 8'h77);

        // Asynchronous reset mid-operation
        apply_stimulus(5'd0, 8'h00);
        repeat (3) @(negedge clk);
        check_output("pre-reset led_out[3:1]", led_out[3:1], 3'h7);
        read_reg(5'd7, rd, rv);
        check_output("pre-reset rdata", rd, 8'h56);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("async reset led_out", led_out, 4'h0);
        check_output("async reset rdata", bus_rdata, 8'h00);
        check_output("async reset rvalid", bus_rvalid, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        read_reg(5'd0, rd, rv);
        check_output("post-reset MODE", rd, 8'h10);
        read_reg(5'd3, rd, rv);
        check_output("post-reset PWM2", rd, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
